// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code-set-2 decoder: tracks E0/F0 prefixes, skips the E1 Pause
// sequence and maintains held-key state for two players.
module ps2_key_decoder #(
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] scan_code,
    input  logic       scan_valid,
    output logic [4:0] p1_keys,
    output logic [4:0] p2_keys,
    output logic       p1_bomb,
    output logic       p2_bomb,
    output logic       kb_reset
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_SKIP
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    skip, skip_n;
    logic [4:0]    p1_n, p2_n;
    logic          kb_reset_n;
    logic [4:0]    p1_mask, p2_mask;
    logic          timeout;

    // Bit order {up,down,left,right,bomb}
    always_comb begin
        p1_mask = '0;
        case (scan_code)
            8'h1D: p1_mask = 5'b10000;
            8'h1B: p1_mask = 5'b01000;
            8'h1C: p1_mask = 5'b00100;
            8'h23: p1_mask = 5'b00010;
            8'h29: p1_mask = 5'b00001;
            default: p1_mask = '0;
        endcase
    end

    always_comb begin
        p2_mask = '0;
        case (scan_code)
            8'h75: p2_mask = 5'b10000;
            8'h72: p2_mask = 5'b01000;
            8'h6B: p2_mask = 5'b00100;
            8'h74: p2_mask = 5'b00010;
            8'h14: p2_mask = 5'b00001;
            default: p2_mask = '0;
        endcase
    end

    // A byte arriving in the timeout cycle takes precedence over the timeout
    assign timeout = (state != S_IDLE) && !scan_valid && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        skip_n     = skip;
        p1_n       = p1_keys;
        p2_n       = p2_keys;
        kb_reset_n = 1'b0;

        if (state != S_IDLE) begin
            if (scan_valid)
                cnt_n = '0;
            else if (timeout)
                cnt_n = '0;
            else
                cnt_n = cnt + 1'b1;
        end else begin
            cnt_n = '0;
        end

        if (timeout) begin
            state_n = S_IDLE;
        end else if (scan_valid) begin
            case (state)
                S_IDLE: begin
                    case (scan_code)
                        8'hE0: state_n = S_EXT;
                        8'hF0: state_n = S_BRK;
                        8'hE1: begin
                            state_n = S_SKIP;
                            skip_n  = 3'd7;
                        end
                        8'hAA, 8'hFC: begin
                            p1_n       = '0;
                            p2_n       = '0;
                            kb_reset_n = 1'b1;
                        end
                        default: p1_n = p1_keys | p1_mask;
                    endcase
                end
                S_EXT: begin
                    if (scan_code == 8'hF0) begin
                        state_n = S_EXT_BRK;
                    end else begin
                        p2_n    = p2_keys | p2_mask;
                        state_n = S_IDLE;
                    end
                end
                S_BRK: begin
                    p1_n    = p1_keys & ~p1_mask;
                    state_n = S_IDLE;
                end
                S_EXT_BRK: begin
                    p2_n    = p2_keys & ~p2_mask;
                    state_n = S_IDLE;
                end
                S_SKIP: begin
                    if (skip == 3'd1)
                        state_n = S_IDLE;
                    skip_n = skip - 1'b1;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            skip     <= '0;
            p1_keys  <= '0;
            p2_keys  <= '0;
            p1_bomb  <= 1'b0;
            p2_bomb  <= 1'b0;
            kb_reset <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            skip     <= skip_n;
            p1_keys  <= p1_n;
            p2_keys  <= p2_n;
            p1_bomb  <= p1_n[0] & ~p1_keys[0];
            p2_bomb  <= p2_n[0] & ~p2_keys[0];
            kb_reset <= kb_reset_n;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed byte streams with hand-computed
// key/pulse expectations, checked by an independent monitor process.
module tb_ps2_key_decoder;

    localparam int T = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] scan_code = 8'h00;
    logic       scan_valid = 1'b0;
    logic [4:0] p1_keys, p2_keys;
    logic       p1_bomb, p2_bomb, kb_reset;

    ps2_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .p1_keys    (p1_keys),
        .p2_keys    (p2_keys),
        .p1_bomb    (p1_bomb),
        .p2_bomb    (p2_bomb),
        .kb_reset   (kb_reset)
    );

    always #5 clk = ~clk;

    // {p1_keys, p2_keys, p1_bomb, p2_bomb, kb_reset}
    logic [12:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          evt     = 0;
    logic        chk_pending = 1'b0;
    logic        mon_en = 1'b0;
    logic [4:0]  last_p1 = '0;
    logic [4:0]  last_p2 = '0;

    always @(posedge clk) chk_pending <= scan_valid | ~rst_n;

    initial begin
        logic [12:0] e;
        logic [12:0] act;
        forever begin
            @(negedge clk);
            act = {p1_keys, p2_keys, p1_bomb, p2_bomb, kb_reset};
            if (chk_pending) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event: got %b with empty queue", act);
                end else begin
                    e = exp_q.pop_front();
                    evt++;
                    if (act !== e) begin
                        n_fail++;
                        $display("FAIL event%0d: got p1=%b p2=%b b1=%b b2=%b kr=%b, want p1=%b p2=%b b1=%b b2=%b kr=%b",
                                 evt, act[12:8], act[7:3], act[2], act[1], act[0],
                                 e[12:8], e[7:3], e[2], e[1], e[0]);
                    end
                    last_p1 = e[12:8];
                    last_p2 = e[7:3];
                    mon_en  = 1'b1;
                end
            end else if (mon_en) begin
                n_tests++;
                if (act !== {last_p1, last_p2, 3'b000}) begin
                    n_fail++;
                    $display("FAIL idle_hold after event%0d: got %b, want %b",
                             evt, act, {last_p1, last_p2, 3'b000});
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic [4:0] e1, input logic [4:0] e2,
                        input logic eb1, input logic eb2, input logic ekr);
        @(negedge clk);
        scan_code  = b;
        scan_valid = 1'b1;
        exp_q.push_back({e1, e2, eb1, eb2, ekr});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            scan_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        scan_valid = 1'b0;
        rst_n      = 1'b0;
        exp_q.push_back('0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Player 1 bomb with typematic repeats, then break
        send(8'h29, 5'b00001, 5'b00000, 1, 0, 0);
        send(8'h29, 5'b00001, 5'b00000, 0, 0, 0);
        send(8'h29, 5'b00001, 5'b00000, 0, 0, 0);
        send(8'hF0, 5'b00001, 5'b00000, 0, 0, 0);
        send(8'h29, 5'b00000, 5'b00000, 0, 0, 0);
        idle(2);

        // Player 2 extended keys
        send(8'hE0, 5'b00000, 5'b00000, 0, 0, 0);
        send(8'h75, 5'b00000, 5'b10000, 0, 0, 0);
        send(8'hE0, 5'b00000, 5'b10000, 0, 0, 0);
        send(8'h14, 5'b00000, 5'b10001, 0, 1, 0);
        send(8'hE0, 5'b00000, 5'b10001, 0, 0, 0);
        send(8'hF0, 5'b00000, 5'b10001, 0, 0, 0);
        send(8'h75, 5'b00000, 5'b00001, 0, 0, 0);

        // Extended flag isolation, opposite directions held together
        send(8'hE0, 5'b00000, 5'b00001, 0, 0, 0);
        send(8'h1D, 5'b00000, 5'b00001, 0, 0, 0);
        send(8'hE0, 5'b00000, 5'b00001, 0, 0, 0);
        send(8'h29, 5'b00000, 5'b00001, 0, 0, 0);
        send(8'h1D, 5'b10000, 5'b00001, 0, 0, 0);
        send(8'h1B, 5'b11000, 5'b00001, 0, 0, 0);
        send(8'hF0, 5'b11000, 5'b00001, 0, 0, 0);
        send(8'h1D, 5'b01000, 5'b00001, 0, 0, 0);
        send(8'hF0, 5'b01000, 5'b00001, 0, 0, 0);
        send(8'h1B, 5'b00000, 5'b00001, 0, 0, 0);

        // Pause sequence is skipped, then a normal make, then self-test reset
        send(8'hE1, 5'b00000, 5'b00001, 0, 0, 0);
        send(8'h14, 5'b00000, 5'b00001, 0, 0, 0);
        send(8'h77, 5'b00000, 5'b00001, 0, 0, 0);
        send(8'hE1, 5'b00000, 5'b00001, 0, 0, 0);
        send(8'hF0, 5'b00000, 5'b00001, 0, 0, 0);
        send(8'h14, 5'b00000, 5'b00001, 0, 0, 0);
        send(8'hF0, 5'b00000, 5'b00001, 0, 0, 0);
        send(8'h77, 5'b00000, 5'b00001, 0, 0, 0);
        send(8'h23, 5'b00010, 5'b00001, 0, 0, 0);
        send(8'hAA, 5'b00000, 5'b00000, 0, 0, 1);
        idle(1);

        // Break prefix timeout: full timeout -> make; one cycle short -> break
        send(8'hF0, 5'b00000, 5'b00000, 0, 0, 0);
        idle(T);
        send(8'h1C, 5'b00100, 5'b00000, 0, 0, 0);
        send(8'hF0, 5'b00100, 5'b00000, 0, 0, 0);
        idle(T - 1);
        send(8'h1C, 5'b00000, 5'b00000, 0, 0, 0);

        // Extended prefix and skip sequence timeouts
        send(8'hE0, 5'b00000, 5'b00000, 0, 0, 0);
        idle(T);
        send(8'h75, 5'b00000, 5'b00000, 0, 0, 0);
        send(8'hE1, 5'b00000, 5'b00000, 0, 0, 0);
        idle(T);
        send(8'h1D, 5'b10000, 5'b00000, 0, 0, 0);

        // Keyboard error code clears keys
        send(8'hFC, 5'b00000, 5'b00000, 0, 0, 1);

        // Reset mid-sequence
        send(8'h1D, 5'b10000, 5'b00000, 0, 0, 0);
        send(8'h29, 5'b10001, 5'b00000, 1, 0, 0);
        send(8'hE0, 5'b10001, 5'b00000, 0, 0, 0);
        do_reset();
        send(8'h75, 5'b00000, 5'b00000, 0, 0, 0);
        send(8'h29, 5'b00001, 5'b00000, 1, 0, 0);
        idle(3);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drain: %0d left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
